// File: rtl/wb_stage.sv
// Write-back stage: selects the result source, extends load data, waits on DMEM
// read data for loads, drives the register file write port and counts retirements.
module wb_stage #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [1:0]                in_wb_sel,
    input  logic [REG_WIDTH-1:0]      in_alu_result,
    input  logic [REG_WIDTH-1:0]      in_pc_plus4,
    input  logic [REG_WIDTH-1:0]      in_imm,
    input  logic [2:0]                in_load_type,
    input  logic                      mem_rvalid,
    input  logic [REG_WIDTH-1:0]      mem_rdata,
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] addr_rd,
    output logic [REG_WIDTH-1:0]      data_rd,
    output logic                      busy,
    output logic [31:0]               instr_retired
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;
    localparam logic [1:0] SEL_IMM = 2'd3;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    state_t                      r_state;
    logic                        r_wr_en;
    logic [REG_ADDR_WIDTH-1:0]   r_addr_rd;
    logic [REG_WIDTH-1:0]        r_data_rd;
    logic                        r_busy;
    logic [31:0]                 r_retired;

    // Load context captured at accept, used when the DMEM word arrives.
    logic                        r_ld_we;
    logic [REG_ADDR_WIDTH-1:0]   r_ld_addr;
    logic [2:0]                  r_ld_type;
    logic [1:0]                  r_ld_off;

    logic [REG_WIDTH-1:0]        w_src;
    logic [REG_WIDTH-1:0]        w_load_ext;
    logic [7:0]                  w_byte;
    logic [15:0]                 w_half;

    assign w_byte = mem_rdata[{r_ld_off, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_ld_off[1], 4'b0000} +: 16];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_src = in_alu_result;
        case (in_wb_sel)
            SEL_PC4: w_src = in_pc_plus4;
            SEL_IMM: w_src = in_imm;
            default: w_src = in_alu_result;
        endcase
    end

    always_comb begin
        w_load_ext = mem_rdata;
        case (r_ld_type)
            LD_B:    w_load_ext = {{(REG_WIDTH-8){w_byte[7]}}, w_byte};
            LD_BU:   w_load_ext = {{(REG_WIDTH-8){1'b0}}, w_byte};
            LD_H:    w_load_ext = {{(REG_WIDTH-16){w_half[15]}}, w_half};
            LD_HU:   w_load_ext = {{(REG_WIDTH-16){1'b0}}, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking (<=).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_addr_rd <= '0;
            r_data_rd <= '0;
            r_busy    <= 1'b0;
            r_retired <= '0;
            r_ld_we   <= 1'b0;
            r_ld_addr <= '0;
            r_ld_type <= '0;
            r_ld_off  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_wb_sel == SEL_MEM) begin
                            r_ld_we   <= in_rd_we;
                            r_ld_addr <= in_rd_addr;
                            r_ld_type <= in_load_type;
                            r_ld_off  <= in_alu_result[1:0];
                            r_busy    <= 1'b1;
                            r_state   <= S_WAIT_MEM;
                        end else begin
                            r_wr_en   <= in_rd_we && (in_rd_addr != '0);
                            r_addr_rd <= in_rd_addr;
                            r_data_rd <= w_src;
                            r_retired <= r_retired + 32'd1;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_wr_en   <= r_ld_we && (r_ld_addr != '0);
                        r_addr_rd <= r_ld_addr;
                        r_data_rd <= w_load_ext;
                        r_retired <= r_retired + 32'd1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign wr_en         = r_wr_en;
    assign addr_rd       = r_addr_rd;
    assign data_rd       = r_data_rd;
    assign busy          = r_busy;
    assign instr_retired = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by random traffic, checked
// against a reference model of the write-back rules.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_rd_we;
    logic [4:0]  in_rd_addr;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_imm;
    logic [2:0]  in_load_type;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wr_en;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        busy;
    logic [31:0] instr_retired;

    int total = 0;
    int bad   = 0;

    // Reference model: what the write port and counter must show right now.
    logic [31:0] m_count;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    wb_stage #(.REG_ADDR_WIDTH(5), .REG_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd_we      (in_rd_we),
        .in_rd_addr    (in_rd_addr),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .in_imm        (in_imm),
        .in_load_type  (in_load_type),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wr_en         (wr_en),
        .addr_rd       (addr_rd),
        .data_rd       (data_rd),
        .busy          (busy),
        .instr_retired (instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] t, input int off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (t)
            3'b000:  return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic scramble_fields();
        in_rd_we      = 1'($urandom);
        in_rd_addr    = 5'($urandom);
        in_wb_sel     = 2'($urandom);
        in_alu_result = $urandom;
        in_pc_plus4   = $urandom;
        in_imm        = $urandom;
        in_load_type  = 3'($urandom);
        mem_rdata     = $urandom;
    endtask

    // Quiet cycle: nothing offered; optionally a stray mem_rvalid that must be ignored.
    task automatic idle_cycle(input string tag, input logic stray_rvalid);
        scramble_fields();
        in_valid   = 1'b0;
        mem_rvalid = stray_rvalid;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check({tag, ".wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, ".addr_hold"}, {27'd0, addr_rd}, {27'd0, m_addr});
        check({tag, ".data_hold"}, data_rd, m_data);
        check({tag, ".count"}, instr_retired, m_count);
        check({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Non-load accepted at the next posedge; leaves in_valid high for back-to-back use.
    task automatic issue(input string tag, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] imm);
        check({tag, ".ready_in"}, {31'd0, in_ready}, 32'd1);
        in_valid      = 1'b1;
        in_rd_we      = we;
        in_rd_addr    = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc_plus4   = pc4;
        in_imm        = imm;
        in_load_type  = 3'($urandom);
        @(negedge clk);
        m_count = m_count + 1;
        m_addr  = rd;
        m_data  = (sel == 2'd2) ? pc4 : (sel == 2'd3) ? imm : alu;
        check({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, (we && rd != 0)});
        check({tag, ".addr"}, {27'd0, addr_rd}, {27'd0, m_addr});
        check({tag, ".data"}, data_rd, m_data);
        check({tag, ".count"}, instr_retired, m_count);
    endtask

    // Load accepted, then mem_rvalid presented so it is sampled 'delay' cycles after accept.
    task automatic load(input string tag, input logic we, input logic [4:0] rd,
                        input logic [2:0] ltype, input int off, input logic [31:0] word,
                        input int delay);
        check({tag, ".ready_in"}, {31'd0, in_ready}, 32'd1);
        in_valid      = 1'b1;
        in_rd_we      = we;
        in_rd_addr    = rd;
        in_wb_sel     = 2'd1;
        in_load_type  = ltype;
        in_alu_result = {$urandom_range(0, 32'h3FFF_FFFF) , 2'(off)} ;
        mem_rvalid    = 1'b0;
        @(negedge clk);
        for (int i = 0; i < delay; i++) begin
            if (i > 0) @(negedge clk);
            scramble_fields();
            in_valid = 1'b0;
            check({tag, ".busy"}, {31'd0, busy}, 32'd1);
            check({tag, ".ready_wait"}, {31'd0, in_ready}, 32'd0);
            check({tag, ".wr_en_wait"}, {31'd0, wr_en}, 32'd0);
            check({tag, ".count_wait"}, instr_retired, m_count);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        m_count = m_count + 1;
        m_addr  = rd;
        m_data  = ref_load(ltype, off, word);
        check({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, (we && rd != 0)});
        check({tag, ".addr"}, {27'd0, addr_rd}, {27'd0, m_addr});
        check({tag, ".data"}, data_rd, m_data);
        check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, ".count"}, instr_retired, m_count);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, ".addr"}, {27'd0, addr_rd}, 32'd0);
        check({tag, ".data"}, data_rd, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, ".count"}, instr_retired, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        scramble_fields();
        m_count = '0;
        m_addr  = '0;
        m_data  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        issue("alu_rd5", 1'b1, 5'd5, 2'd0, 32'h0000_1234, 32'h1, 32'h2);
        idle_cycle("idle_a", 1'b0);
        issue("alu_x0", 1'b1, 5'd0, 2'd0, 32'h0000_FFFF, 32'h1, 32'h2);
        idle_cycle("idle_b", 1'b1);

        load("lb_off3", 1'b1, 5'd7, 3'b000, 3, 32'h8000_0000, 4);
        load("lbu_off3", 1'b1, 5'd7, 3'b100, 3, 32'h8000_0000, 4);
        load("lh_off2", 1'b1, 5'd9, 3'b001, 2, 32'h8001_0000, 1);
        load("lhu_off3", 1'b1, 5'd9, 3'b101, 3, 32'h8001_0000, 2);
        load("lw_x0", 1'b1, 5'd0, 3'b010, 1, 32'hDEAD_BEEF, 1);
        load("ld_noweb", 1'b0, 5'd3, 3'b111, 0, 32'hCAFE_F00D, 3);

        issue("b2b_pc4", 1'b1, 5'd1, 2'd2, 32'h11, 32'h0000_1004, 32'h33);
        issue("b2b_imm", 1'b1, 5'd2, 2'd3, 32'h11, 32'h22, 32'hABCD_E000);
        issue("b2b_alu", 1'b1, 5'd3, 2'd0, 32'h5555_AAAA, 32'h22, 32'h33);
        idle_cycle("idle_c", 1'b0);

        // Reset in WAIT_MEM coinciding with mem_rvalid: no write, counter cleared.
        in_valid      = 1'b1;
        in_rd_we      = 1'b1;
        in_rd_addr    = 5'd12;
        in_wb_sel     = 2'd1;
        in_load_type  = 3'b010;
        in_alu_result = 32'h0;
        @(negedge clk);
        in_valid   = 1'b0;
        check("rst_wait.busy", {31'd0, busy}, 32'd1);
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        m_count = '0;
        m_addr  = '0;
        m_data  = '0;
        check_reset_state("rst_wait");

        // Reset alongside an accept: the accept is dropped.
        in_valid      = 1'b1;
        in_rd_we      = 1'b1;
        in_rd_addr    = 5'd4;
        in_wb_sel     = 2'd0;
        in_alu_result = 32'h0BAD_0BAD;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_state("rst_accept");
        reset = 1'b0;
        idle_cycle("idle_d", 1'b1);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0, 1: issue("rnd_op", 1'($urandom), 5'($urandom), 2'($urandom_range(0, 1) * 2 + $urandom_range(0, 1) * ($urandom_range(0,1) ? 1 : 0)) | 2'b00 == 2'd1 ? 2'd0 : 2'($urandom_range(0, 1) * 2 + $urandom_range(0, 1)) == 2'd1 ? 2'd3 : 2'($urandom_range(2, 3)),
                            $urandom, $urandom, $urandom);
                2: load("rnd_ld", 1'($urandom), 5'($urandom), 3'($urandom), $urandom_range(0, 3),
                        $urandom, $urandom_range(1, 4));
                default: idle_cycle("rnd_idle", 1'($urandom));
            endcase
        end
        idle_cycle("idle_end", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
